// File: rtl/onchip_mem_stream_master.sv
// onchip_mem_stream_master: Avalon-MM on-chip RAM reader presenting words as a valid/ready stream.
// Defining STREAM_MASTER_LOOP_EN enables circular replay of the programmed window via the loop input.
module onchip_mem_stream_master #(
    parameter int MEM_WORDS    = 3840,
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              loop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [12:0]       word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata,
    output logic [31:0]       src_data,
    output logic              src_valid,
    input  logic              src_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int UW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    logic                    aborting;
    logic [ADDR_W-1:0]       base_r, nxt_addr, iss_addr, ld_base;
    logic [12:0]             cnt_r, rem, acc_idx, iss_rem, ld_cnt;
    logic [UW-1:0]           used, used_p, fcnt;
    logic [PW-1:0]           wp, rp;
    logic [31:0]             mem [FIFO_DEPTH];
    logic [READ_LATENCY-1:0] tags;
    logic                    loop_s, go, kill, pop, push, can, last;

    function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] a);
        return a == ADDR_W'(MEM_WORDS - 1) ? '0 : a + 1'b1;
    endfunction

`ifdef STREAM_MASTER_LOOP_EN
    assign loop_s = loop;
`else
    assign loop_s = loop & 1'b0;
`endif

    assign avm_byteenable = 4'hF;
    assign avm_write      = 1'b0;
    assign avm_writedata  = '0;
    assign avm_clken      = 1'b1;
    assign busy           = state != IDLE;
    assign src_valid      = fcnt != '0;
    assign src_data       = mem[rp];

    assign go       = state == IDLE && start && !abort && word_count != '0;
    assign kill     = state != IDLE && abort;
    assign pop      = src_valid && src_ready;
    assign push     = tags[READ_LATENCY-1] && !aborting;
    // used reserves a FIFO slot from the moment a read is decided until its word is popped
    assign used_p   = used - UW'(pop);
    assign can      = (go || (state == RUN && !abort)) && used_p < UW'(FIFO_DEPTH);
    assign iss_addr = go ? base_addr : nxt_addr;
    assign iss_rem  = go ? word_count : rem;
    assign ld_base  = go ? base_addr : base_r;
    assign ld_cnt   = go ? word_count : cnt_r;
    assign last     = iss_rem == 13'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            aborting       <= 1'b0;
            done           <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            base_r         <= '0;
            nxt_addr       <= '0;
            cnt_r          <= '0;
            rem            <= '0;
            acc_idx        <= '0;
            used           <= '0;
            tags           <= '0;
        end else begin
            done <= 1'b0;
            tags <= (tags << 1) | READ_LATENCY'(avm_chipselect);
            if (kill) begin
                state          <= DRAIN;
                aborting       <= 1'b1;
                avm_chipselect <= 1'b0;
                used           <= '0;
            end else begin
                avm_chipselect <= can;
                used           <= used_p + UW'(can);
                if (can) begin
                    avm_address <= iss_addr;
                    nxt_addr    <= last && loop_s ? ld_base : wrap(iss_addr);
                    rem         <= last && loop_s ? ld_cnt : iss_rem - 13'd1;
                    if (last && !loop_s)
                        state <= DRAIN;
                    else if (go)
                        state <= RUN;
                end
                if (go) begin
                    base_r  <= base_addr;
                    cnt_r   <= word_count;
                    acc_idx <= '0;
                end
                if (state == IDLE && start && !abort && word_count == '0)
                    done <= 1'b1;
                if (pop) begin
                    acc_idx <= acc_idx == cnt_r - 13'd1 ? '0 : acc_idx + 13'd1;
                    done    <= acc_idx == cnt_r - 13'd1;
                end
                if (state == DRAIN && !aborting && pop && used == UW'(1))
                    state <= IDLE;
                // aborted reads still return; wait for the tag pipe to empty before idling
                if (aborting && tags == '0) begin
                    state    <= IDLE;
                    aborting <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt <= '0;
            wp   <= '0;
            rp   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else if (kill) begin
            fcnt <= '0;
            wp   <= '0;
            rp   <= '0;
        end else begin
            if (push) begin
                mem[wp] <= avm_readdata;
                wp      <= wp + 1'b1;
            end
            if (pop)
                rp <= rp + 1'b1;
            fcnt <= fcnt + UW'(push) - UW'(pop);
        end
    end
endmodule

// File: tb/tb_onchip_mem_stream_master.sv
// tb_onchip_mem_stream_master: randomized stream checks against a RAM-window model of the reader.
module tb_onchip_mem_stream_master;
    localparam int MW = 3840;
    localparam int D  = 4;

    logic        clk = 0, reset = 1, start = 0, abort = 0, loop = 0, src_ready = 1;
    logic [11:0] base_addr = '0;
    logic [12:0] word_count = '0;
    logic        busy, done, avm_chipselect, avm_write, avm_clken, src_valid;
    logic [11:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata, avm_readdata, src_data;

    logic [31:0] ram [MW];
    logic [31:0] rd = '0;
    int          n_chk = 0, n_fail = 0;

    logic [31:0] got[$];
    logic [11:0] iss[$];
    int          acc_cyc[$], done_pos[$];
    int          cyc = 0, ahead_max = 0, stall_err = 0;
    logic        mon_clr = 0, prev_v = 0, prev_r = 0;
    logic [31:0] prev_d = '0;

    onchip_mem_stream_master dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .loop(loop),
        .base_addr(base_addr), .word_count(word_count), .busy(busy), .done(done),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_clken(avm_clken),
        .avm_readdata(avm_readdata), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready)
    );

    always #5 clk = ~clk;

    // RAM slave with one cycle of read latency
    always @(posedge clk) if (avm_chipselect) rd <= ram[avm_address];
    assign avm_readdata = rd;

    always @(posedge clk) begin
        if (mon_clr || reset) begin
            got.delete(); iss.delete(); acc_cyc.delete(); done_pos.delete();
            ahead_max <= 0; stall_err <= 0; prev_v <= 0; prev_r <= 0;
        end else begin
            cyc <= cyc + 1;
            if (done) done_pos.push_back(got.size());
            if (prev_v && !prev_r && (!src_valid || src_data !== prev_d)) stall_err <= stall_err + 1;
            if (int'(iss.size()) + int'(avm_chipselect) - int'(got.size()) - int'(src_valid && src_ready) > ahead_max)
                ahead_max <= int'(iss.size()) + int'(avm_chipselect) - int'(got.size()) - int'(src_valid && src_ready);
            if (avm_chipselect) iss.push_back(avm_address);
            if (src_valid && src_ready) begin
                got.push_back(src_data);
                acc_cyc.push_back(cyc);
            end
            prev_v <= src_valid; prev_r <= src_ready; prev_d <= src_data;
        end
    end

    task automatic clear_mon();
        @(negedge clk); mon_clr = 1;
        @(negedge clk); mon_clr = 0;
    endtask

    // base/count are scrambled right after the pulse: they must not matter once busy
    task automatic start_xfer(input logic [11:0] b, input logic [12:0] c);
        @(negedge clk); base_addr = b; word_count = c; start = 1;
        @(negedge clk); start = 0; base_addr = 12'($urandom); word_count = 13'($urandom);
    endtask

    task automatic run_until_idle(input int mode, input int limit, output bit to);
        logic [3:0] pat = 4'b1001;
        to = 1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            src_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[i % 4] : 1'($urandom);
            if (!busy) begin to = 0; break; end
        end
        @(negedge clk); src_ready = 1;
    endtask

    task automatic test_reset();
        n_chk++; if (busy !== 0 || done !== 0) begin n_fail++; $display("FAIL reset_busy_done: busy=%0b done=%0b, want 0 0", busy, done); end
        n_chk++; if (avm_address !== 0 || avm_chipselect !== 0) begin n_fail++; $display("FAIL reset_avm: addr=%0h cs=%0b, want 0 0", avm_address, avm_chipselect); end
        n_chk++; if (src_valid !== 0 || src_data !== 0) begin n_fail++; $display("FAIL reset_src: valid=%0b data=%0h, want 0 0", src_valid, src_data); end
        n_chk++; if (avm_byteenable !== 4'hF || avm_clken !== 1 || avm_write !== 0 || avm_writedata !== 0) begin
            n_fail++; $display("FAIL reset_consts: be=%0h clken=%0b wr=%0b wd=%0h, want f 1 0 0", avm_byteenable, avm_clken, avm_write, avm_writedata); end
    endtask

    task automatic test_basic();
        bit to;
        clear_mon(); src_ready = 1;
        start_xfer(12'h010, 13'd8);
        n_chk++; if (busy !== 1 || avm_chipselect !== 1 || avm_address !== 12'h010) begin
            n_fail++; $display("FAIL basic_issue: busy=%0b cs=%0b addr=%0h, want 1 1 10", busy, avm_chipselect, avm_address); end
        @(negedge clk);
        n_chk++; if (src_valid !== 0) begin n_fail++; $display("FAIL basic_early_valid: valid=%0b, want 0", src_valid); end
        @(negedge clk);
        n_chk++; if (src_valid !== 1 || src_data !== ram[16]) begin
            n_fail++; $display("FAIL basic_first_word: valid=%0b data=%0h, want 1 %0h", src_valid, src_data, ram[16]); end
        run_until_idle(0, 100, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL basic_timeout: busy still %0b, want 0", busy); end
        n_chk++; if (got.size() != 8) begin n_fail++; $display("FAIL basic_len: got %0d words, want 8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_chk++; if (got[i] !== ram[16 + i]) begin n_fail++; $display("FAIL basic_data[%0d]: %0h, want %0h", i, got[i], ram[16 + i]); end
        end
        n_chk++; if (got.size() == 8 && acc_cyc[7] - acc_cyc[0] != 7) begin
            n_fail++; $display("FAIL basic_rate: 8 words over %0d cycles, want 7", acc_cyc[7] - acc_cyc[0]); end
        n_chk++; if (done_pos.size() != 1 || done_pos[0] != 8) begin
            n_fail++; $display("FAIL basic_done: %0d pulses, first after word %0d, want 1 after 8", done_pos.size(), done_pos.size() ? done_pos[0] : -1); end
    endtask

    task automatic test_wrap();
        bit to;
        int exp_a [4] = '{3838, 3839, 0, 1};
        clear_mon();
        start_xfer(12'hEFE, 13'd4);
        run_until_idle(0, 100, to);
        n_chk++; if (to || iss.size() != 4) begin n_fail++; $display("FAIL wrap_issues: timeout=%0b issues=%0d, want 0 4", to, iss.size()); end
        for (int i = 0; i < 4 && i < iss.size() && i < got.size(); i++) begin
            n_chk++; if (iss[i] !== 12'(exp_a[i]) || got[i] !== ram[exp_a[i]]) begin
                n_fail++; $display("FAIL wrap[%0d]: addr=%0h data=%0h, want %0h %0h", i, iss[i], got[i], exp_a[i], ram[exp_a[i]]); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [11:0] b = 12'($urandom_range(0, MW - 1));
        clear_mon();
        start_xfer(b, 13'd16);
        run_until_idle(1, 300, to);
        n_chk++; if (to || got.size() != 16) begin n_fail++; $display("FAIL bp_len: timeout=%0b words=%0d, want 0 16", to, got.size()); end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_chk++; if (got[i] !== ram[(b + i) % MW]) begin n_fail++; $display("FAIL bp_data[%0d]: %0h, want %0h", i, got[i], ram[(b + i) % MW]); end
        end
        n_chk++; if (ahead_max > D) begin n_fail++; $display("FAIL bp_credit: %0d words ahead, want <= %0d", ahead_max, D); end
        n_chk++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stalls, want 0", stall_err); end
        n_chk++; if (done_pos.size() != 1) begin n_fail++; $display("FAIL bp_done: %0d pulses, want 1", done_pos.size()); end
    endtask

    task automatic test_zero();
        clear_mon();
        start_xfer(12'h123, 13'd0);
        n_chk++; if (done !== 1 || busy !== 0 || avm_chipselect !== 0) begin
            n_fail++; $display("FAIL zero_done: done=%0b busy=%0b cs=%0b, want 1 0 0", done, busy, avm_chipselect); end
        repeat (3) @(negedge clk);
        n_chk++; if (done !== 0 || busy !== 0 || iss.size() != 0) begin
            n_fail++; $display("FAIL zero_quiet: done=%0b busy=%0b issues=%0d, want 0 0 0", done, busy, iss.size()); end
    endtask

    task automatic test_abort();
        bit to;
        logic [11:0] b = 12'($urandom_range(0, MW - 1));
        clear_mon();
        start_xfer(b, 13'd32);
        for (int i = 0; i < 60 && got.size() < 5; i++) @(negedge clk);
        abort = 1;
        @(negedge clk); abort = 0;
        n_chk++; if (src_valid !== 0) begin n_fail++; $display("FAIL abort_valid: valid=%0b, want 0", src_valid); end
        run_until_idle(0, 50, to);
        n_chk++; if (to || done_pos.size() != 0) begin n_fail++; $display("FAIL abort_idle: timeout=%0b done pulses=%0d, want 0 0", to, done_pos.size()); end
        n_chk++; if (got.size() < 5 || got.size() > 6) begin n_fail++; $display("FAIL abort_count: %0d words, want 5..6", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_chk++; if (got[i] !== ram[(b + i) % MW]) begin n_fail++; $display("FAIL abort_data[%0d]: %0h, want %0h", i, got[i], ram[(b + i) % MW]); end
        end
        clear_mon();
        b = 12'($urandom_range(0, MW - 1));
        start_xfer(b, 13'd6);
        run_until_idle(0, 100, to);
        n_chk++; if (to || got.size() != 6 || done_pos.size() != 1) begin
            n_fail++; $display("FAIL abort_restart: timeout=%0b words=%0d done=%0d, want 0 6 1", to, got.size(), done_pos.size()); end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            n_chk++; if (got[i] !== ram[(b + i) % MW]) begin n_fail++; $display("FAIL restart_data[%0d]: %0h, want %0h", i, got[i], ram[(b + i) % MW]); end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [11:0] b = 12'($urandom_range(0, MW - 1));
        logic [11:0] b2 = 12'($urandom_range(0, MW - 1));
        clear_mon();
        start_xfer(b, 13'd10);
        @(negedge clk); base_addr = b2; word_count = 13'd3; start = 1;
        @(negedge clk); start = 0;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        base_addr = b2; word_count = 13'd3; start = 1;
        @(negedge clk); start = 0;
        run_until_idle(0, 100, to);
        n_chk++; if (to || got.size() != 13 || done_pos.size() != 2) begin
            n_fail++; $display("FAIL b2b_len: timeout=%0b words=%0d done=%0d, want 0 13 2", to, got.size(), done_pos.size()); end
        for (int i = 0; i < got.size() && i < 13; i++) begin
            n_chk++; if (got[i] !== (i < 10 ? ram[(b + i) % MW] : ram[(b2 + i - 10) % MW])) begin
                n_fail++; $display("FAIL b2b_data[%0d]: %0h, want %0h", i, got[i], i < 10 ? ram[(b + i) % MW] : ram[(b2 + i - 10) % MW]); end
        end
    endtask

    task automatic test_random();
        bit to;
        logic [11:0] b;
        int c;
        for (int k = 0; k < 6; k++) begin
            b = 12'(k % 2 ? MW - 1 - $urandom_range(0, 20) : $urandom_range(0, MW - 1));
            c = $urandom_range(1, 40);
            clear_mon();
            start_xfer(b, 13'(c));
            run_until_idle(2, 1000, to);
            n_chk++; if (to || got.size() != c || done_pos.size() != 1) begin
                n_fail++; $display("FAIL rand%0d_len: timeout=%0b words=%0d done=%0d, want 0 %0d 1", k, to, got.size(), done_pos.size(), c); end
            for (int i = 0; i < got.size() && i < c; i++) begin
                n_chk++; if (got[i] !== ram[(b + i) % MW]) begin n_fail++; $display("FAIL rand%0d_data[%0d]: %0h, want %0h", k, i, got[i], ram[(b + i) % MW]); end
            end
            n_chk++; if (ahead_max > D || stall_err != 0) begin
                n_fail++; $display("FAIL rand%0d_flow: ahead=%0d stalls=%0d, want <=%0d 0", k, ahead_max, stall_err, D); end
        end
    endtask

    task automatic test_loop();
        bit to;
        logic [11:0] b = 12'(MW - 2);
        clear_mon();
        loop = 1;
        start_xfer(b, 13'd3);
`ifdef STREAM_MASTER_LOOP_EN
        for (int i = 0; i < 100 && got.size() < 10; i++) @(negedge clk);
        loop = 0;
        run_until_idle(0, 100, to);
        n_chk++; if (to || got.size() < 10 || got.size() % 3 != 0) begin
            n_fail++; $display("FAIL loop_len: timeout=%0b words=%0d, want 0 and whole passes >= 10", to, got.size()); end
`else
        run_until_idle(0, 100, to);
        loop = 0;
        n_chk++; if (to || got.size() != 3) begin n_fail++; $display("FAIL loop_off_len: timeout=%0b words=%0d, want 0 3", to, got.size()); end
`endif
        for (int i = 0; i < got.size(); i++) begin
            n_chk++; if (got[i] !== ram[(b + i % 3) % MW]) begin n_fail++; $display("FAIL loop_data[%0d]: %0h, want %0h", i, got[i], ram[(b + i % 3) % MW]); end
        end
        n_chk++; if (done_pos.size() != got.size() / 3) begin n_fail++; $display("FAIL loop_done: %0d pulses, want %0d", done_pos.size(), got.size() / 3); end
        for (int k = 0; k < done_pos.size(); k++) begin
            n_chk++; if (done_pos[k] != 3 * (k + 1)) begin n_fail++; $display("FAIL loop_done_pos[%0d]: after word %0d, want %0d", k, done_pos[k], 3 * (k + 1)); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [11:0] b = 12'($urandom_range(0, MW - 1));
        clear_mon();
        loop = 1;
        start_xfer(b, 13'd20);
        repeat (6) @(negedge clk);
        #2 reset = 1;
        #1;
        n_chk++; if (busy !== 0 || done !== 0 || avm_chipselect !== 0 || avm_address !== 0) begin
            n_fail++; $display("FAIL rstmid_ctrl: busy=%0b done=%0b cs=%0b addr=%0h, want 0 0 0 0", busy, done, avm_chipselect, avm_address); end
        n_chk++; if (src_valid !== 0 || src_data !== 0) begin
            n_fail++; $display("FAIL rstmid_src: valid=%0b data=%0h, want 0 0", src_valid, src_data); end
        @(negedge clk); reset = 0; loop = 0;
        clear_mon();
        b = 12'($urandom_range(0, MW - 1));
        start_xfer(b, 13'd5);
        run_until_idle(0, 100, to);
        n_chk++; if (to || got.size() != 5) begin n_fail++; $display("FAIL rstmid_after: timeout=%0b words=%0d, want 0 5", to, got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            n_chk++; if (got[i] !== ram[(b + i) % MW]) begin n_fail++; $display("FAIL rstmid_data[%0d]: %0h, want %0h", i, got[i], ram[(b + i) % MW]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MW; i++) ram[i] = $urandom;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 0;
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero();
        test_abort();
        test_back_to_back();
        test_random();
        test_loop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
